font_text_blitter: RTL and testbench

- Controller that sequences the shared glyph ROM to render a text string into the pixel stream.
- Accepts a string (length, origin) and fetches each character code from a text buffer.
- Scans each glyph cell row-major through the font ROM lookup port, emitting one pixel per cell position on a valid/ready stream toward the framebuffer writer.
- Sits between the HUD/text layer logic and the framebuffer write arbiter.

---
 rtl/font_blit_pkg.sv | 23 ++
 rtl/font_text_blitter_scan.sv | 60 ++++++
 rtl/font_text_blitter.sv | 159 +++++++++++++++
 tb/tb_font_text_blitter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/font_blit_pkg.sv
// font_blit_pkg: shared FSM state and default geometry for the text blitter.
// Optional build macro FONT_BLIT_TRANSPARENT_SKIP_EN is consumed by the top.
package font_blit_pkg;

  localparam int DEF_CHAR_W  = 17;
  localparam int DEF_CHAR_H  = 17;
  localparam int DEF_MAX_LEN = 32;
  localparam int DEF_COORD_W = 10;

  localparam int DEF_LEN_W  = $clog2(DEF_MAX_LEN + 1);
  localparam int DEF_ADDR_W = $clog2(DEF_MAX_LEN);
  localparam int DEF_COL_W  = $clog2(DEF_CHAR_W);
  localparam int DEF_ROW_W  = $clog2(DEF_CHAR_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_DRAW,
    S_DONE
  } blit_state_e;

endpackage

// File: rtl/font_text_blitter_scan.sv
// glyph_scan_counter: row-major col/row walk over one glyph cell.
// Wraps to (0,0) after the last cell; last_cell_o flags (H-1,W-1).
module glyph_scan_counter
  import font_blit_pkg::*;
#(
  parameter int CHAR_W = DEF_CHAR_W,
  parameter int CHAR_H = DEF_CHAR_H,
  localparam int COL_W = $clog2(CHAR_W),
  localparam int ROW_W = $clog2(CHAR_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             advance_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_cell_o
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             col_end;
  logic             row_end;

  assign col_end = (col_q == COL_W'(CHAR_W - 1));
  assign row_end = (row_q == ROW_W'(CHAR_H - 1));

  assign col_o       = col_q;
  assign row_o       = row_q;
  assign last_cell_o = col_end && row_end;

  // next cell: clear wins, otherwise step column then row
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (advance_i) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/font_text_blitter.sv
// font_text_blitter: walks a text string through the glyph ROM and streams pixels.
// Define FONT_BLIT_TRANSPARENT_SKIP_EN to drop background cells from the stream.
module font_text_blitter
  import font_blit_pkg::*;
#(
  parameter int CHAR_W  = DEF_CHAR_W,
  parameter int CHAR_H  = DEF_CHAR_H,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int COORD_W = DEF_COORD_W,
  localparam int LEN_W  = $clog2(MAX_LEN + 1),
  localparam int ADDR_W = $clog2(MAX_LEN),
  localparam int COL_W  = $clog2(CHAR_W),
  localparam int ROW_W  = $clog2(CHAR_H)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   str_len,
  input  logic [COORD_W-1:0] org_x,
  input  logic [COORD_W-1:0] org_y,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  txt_addr,
  input  logic [7:0]         txt_char,
  output logic [7:0]         font_char,
  output logic [COL_W-1:0]   font_x,
  output logic [ROW_W-1:0]   font_y,
  input  logic               font_bit,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic               px_on
);

  blit_state_e        state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   idx_nx;
  logic [LEN_W-1:0]   len_clamp;
  logic [COORD_W-1:0] org_x_q, org_x_d;
  logic [COORD_W-1:0] org_y_q, org_y_d;
  logic [7:0]         glyph_q, glyph_d;

  logic               scan_clr;
  logic               scan_adv;
  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   row;
  logic               last_cell;

  assign len_clamp = (str_len > LEN_W'(MAX_LEN)) ?
                     LEN_W'(MAX_LEN) : str_len;
  assign idx_nx    = idx_q + LEN_W'(1);

  glyph_scan_counter #(
    .CHAR_W (CHAR_W),
    .CHAR_H (CHAR_H)
  ) u_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (scan_clr),
    .advance_i   (scan_adv),
    .col_o       (col),
    .row_o       (row),
    .last_cell_o (last_cell)
  );

  // sequencing: next state, latches and all outputs
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    org_x_d   = org_x_q;
    org_y_d   = org_y_q;
    glyph_d   = glyph_q;
    scan_clr  = 1'b0;
    scan_adv  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    txt_addr  = '0;
    font_char = '0;
    font_x    = '0;
    font_y    = '0;
    px_valid  = 1'b0;
    px_x      = '0;
    px_y      = '0;
    px_on     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len_clamp;
          org_x_d = org_x;
          org_y_d = org_y;
          idx_d   = '0;
          state_d = (len_clamp == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        busy     = 1'b1;
        txt_addr = ADDR_W'(idx_q);
        state_d  = S_LOAD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        glyph_d  = txt_char;
        scan_clr = 1'b1;
        state_d  = S_DRAW;
      end
      S_DRAW: begin
        busy      = 1'b1;
        font_char = glyph_q;
        font_x    = col;
        font_y    = row;
        px_x      = org_x_q
                  + COORD_W'(idx_q) * COORD_W'(CHAR_W)
                  + COORD_W'(col);
        px_y      = org_y_q + COORD_W'(row);
        px_on     = font_bit;
`ifdef FONT_BLIT_TRANSPARENT_SKIP_EN
        // background cells are stepped over without a handshake
        px_valid  = font_bit;
        scan_adv  = !font_bit || px_ready;
`else
        px_valid  = 1'b1;
        scan_adv  = px_ready;
`endif
        if (scan_adv && last_cell) begin
          idx_d   = idx_nx;
          state_d = (idx_nx < len_q) ? S_FETCH : S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and latched request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      org_x_q <= '0;
      org_y_q <= '0;
      glyph_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      org_x_q <= org_x_d;
      org_y_q <= org_y_d;
      glyph_q <= glyph_d;
    end
  end

endmodule

// File: tb/tb_font_text_blitter.sv
// tb_font_text_blitter: directed checks of the text blitter.
// Golden font: glyph 0x5A is an 8x5 block, others a diagonal stripe.
module tb_font_text_blitter;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       on;
    logic [7:0] ch;
    logic [4:0] c;
    logic [4:0] r;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] str_len = '0;
  logic [9:0] org_x = '0;
  logic [9:0] org_y = '0;
  logic       busy, done;
  logic [4:0] txt_addr;
  logic [7:0] txt_char = '0;
  logic [7:0] font_char;
  logic [4:0] font_x, font_y;
  logic       font_bit;
  logic       px_valid;
  logic       px_ready = 1'b0;
  logic [9:0] px_x, px_y;
  logic       px_on;

  logic [7:0] txt_mem [32];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  int hs, exp_n, busy_n, gap;
  int first_t, done_t, last_hs_t;
  logic [9:0] fx [32];
  logic [9:0] fy [32];
  logic [9:0] rx [17];
  logic [9:0] lx, ly;

  font_text_blitter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .str_len   (str_len),
    .org_x     (org_x),
    .org_y     (org_y),
    .busy      (busy),
    .done      (done),
    .txt_addr  (txt_addr),
    .txt_char  (txt_char),
    .font_char (font_char),
    .font_x    (font_x),
    .font_y    (font_y),
    .font_bit  (font_bit),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_on     (px_on)
  );

  always #5 clk = ~clk;

  always @(posedge clk) txt_char <= txt_mem[txt_addr];

  function automatic logic rom(input logic [7:0] ch,
                               input logic [4:0] c,
                               input logic [4:0] r);
    if (ch == 8'h5A) return (c < 5'd8) && (r < 5'd5);
    return ((int'(c) + 2 * int'(r) + int'(ch)) % 3) == 0;
  endfunction

  assign font_bit = rom(font_char, font_x, font_y);

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int len, input int ox, input int oy,
                     input bit rnd, input bit poke);
    pix_t exp_q[$];
    pix_t e, cur, held_v;
    bit   held;
    int   nl, budget;
    logic b;
    nl = (len > 32) ? 32 : len;
    for (int ci = 0; ci < nl; ci++)
      for (int r = 0; r < 17; r++)
        for (int c = 0; c < 17; c++) begin
          b = rom(txt_mem[ci], 5'(c), 5'(r));
`ifdef FONT_BLIT_TRANSPARENT_SKIP_EN
          if (!b) continue;
`endif
          e.x  = 10'(ox + ci * 17 + c);
          e.y  = 10'(oy + r);
          e.on = b;
          e.ch = txt_mem[ci];
          e.c  = 5'(c);
          e.r  = 5'(r);
          exp_q.push_back(e);
        end
    exp_n = exp_q.size();
    hs = 0; busy_n = 0; gap = 0;
    first_t = -1; done_t = -1; last_hs_t = -1;
    held = 1'b0;
    held_v = '0;
    budget = nl * 289 * 4 + 60;
    @(negedge clk);
    start = 1'b1;
    str_len = 6'(len);
    org_x = 10'(ox);
    org_y = 10'(oy);
    px_ready = 1'b1;
    for (int t = 1; t <= budget && done_t < 0; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && t == 10) begin
        start = 1'b1;
        str_len = 6'd5;
        org_x = 10'(ox + 300);
        org_y = 10'(oy + 200);
      end
      px_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cur = {px_x, px_y, px_on, font_char, font_x, font_y};
      if (held) check("stall_hold", {px_valid, cur}, {1'b1, held_v});
      held = 1'b0;
      if (busy) busy_n++;
      if (first_t < 0 && px_valid) first_t = t;
      if (first_t >= 0 && busy && !px_valid) gap++;
      if (px_valid && px_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_pixel", 64'(hs + 1), 64'(exp_n));
        end else begin
          e = exp_q.pop_front();
          check("pixel", 64'(cur), 64'(e));
        end
        if (hs % 289 == 0 && hs / 289 < 32) begin
          fx[hs / 289] = px_x;
          fy[hs / 289] = px_y;
        end
        if (hs < 17) rx[hs] = px_x;
        lx = px_x;
        ly = px_y;
        hs++;
        last_hs_t = t;
      end else if (px_valid) begin
        held = 1'b1;
        held_v = cur;
      end
      if (done) done_t = t;
    end
    check("done_seen", 64'(done_t >= 0), 64'(1));
    check("hs_vs_model", 64'(hs), 64'(exp_n));
  endtask

  initial begin
    int dn;
    for (int i = 0; i < 32; i++) txt_mem[i] = 8'h41 + 8'(i % 26);

    repeat (2) @(negedge clk);
    check("reset_outputs",
          {busy, done, px_valid, px_x, px_y, px_on,
           font_char, font_x, font_y, txt_addr}, '0);
    rst_n = 1'b1;

`ifdef FONT_BLIT_TRANSPARENT_SKIP_EN
    txt_mem[0] = 8'h5A;
    run(1, 100, 50, 1'b0, 1'b0);
    check("skip_hs", 64'(hs), 64'd40);
    check("skip_draw_time", 64'(busy_n), 64'd291);
    check("skip_first_t", 64'(first_t), 64'd3);
    check("skip_first", {fx[0], fy[0]}, {10'd100, 10'd50});
    check("skip_last", {lx, ly}, {10'd107, 10'd54});
    run(1, 100, 50, 1'b1, 1'b0);
    check("skip_bp_hs", 64'(hs), 64'd40);
    check("skip_bp_last", {lx, ly}, {10'd107, 10'd54});
    txt_mem[0] = 8'h41;
`else
    txt_mem[0] = 8'h41;
    run(1, 100, 50, 1'b0, 1'b0);
    check("one_hs", 64'(hs), 64'd289);
    check("one_first", {fx[0], fy[0]}, {10'd100, 10'd50});
    check("one_last", {lx, ly}, {10'd116, 10'd66});
    check("one_first_t", 64'(first_t), 64'd3);
    check("one_done_t", 64'(done_t), 64'(last_hs_t + 1));
    check("one_busy", 64'(busy_n), 64'd291);

    run(1, 100, 50, 1'b1, 1'b0);
    check("bp_hs", 64'(hs), 64'd289);
    check("bp_last", {lx, ly}, {10'd116, 10'd66});
    check("bp_done_t", 64'(done_t), 64'(last_hs_t + 1));

    txt_mem[0] = 8'h41;
    txt_mem[1] = 8'h42;
    txt_mem[2] = 8'h43;
    run(3, 0, 0, 1'b0, 1'b0);
    check("multi_hs", 64'(hs), 64'd867);
    check("multi_c1", {fx[1], fy[1]}, {10'd17, 10'd0});
    check("multi_c2", {fx[2], fy[2]}, {10'd34, 10'd0});
    check("multi_gap", 64'(gap), 64'd4);
    check("multi_busy", 64'(busy_n), 64'd873);

    run(1, 100, 50, 1'b0, 1'b1);
    check("poke_hs", 64'(hs), 64'd289);
    check("poke_last", {lx, ly}, {10'd116, 10'd66});
    repeat (3) @(negedge clk);
    check("poke_idle", 64'(busy), 64'd0);

    run(1, 1020, 0, 1'b0, 1'b0);
    check("wrap_x0", 64'(rx[0]), 64'd1020);
    check("wrap_x3", 64'(rx[3]), 64'd1023);
    check("wrap_x4", 64'(rx[4]), 64'd0);
    check("wrap_x16", 64'(rx[16]), 64'd12);

    run(40, 0, 0, 1'b0, 1'b0);
    check("clamp_hs", 64'(hs), 64'd9248);
    check("clamp_c31", 64'(fx[31]), 64'd527);
`endif

    run(0, 7, 7, 1'b0, 1'b0);
    check("zero_done_t", 64'(done_t), 64'd1);
    check("zero_no_valid", 64'(first_t < 0), 64'd1);
    check("zero_busy", 64'(busy_n), 64'd0);

    txt_mem[0] = 8'h41;
    txt_mem[1] = 8'h42;
    @(negedge clk);
    start = 1'b1;
    str_len = 6'd2;
    org_x = 10'd5;
    org_y = 10'd5;
    @(negedge clk);
    start = 1'b0;
    px_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_pre_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_outputs",
          {busy, done, px_valid, px_x, px_y, px_on,
           font_char, font_x, font_y, txt_addr}, '0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("rst_no_done", 64'(dn), 64'd0);
    rst_n = 1'b1;
    run(1, 100, 50, 1'b0, 1'b0);
    check("restart_first", {fx[0], fy[0]}, {10'd100, 10'd50});
    check("restart_first_t", 64'(first_t), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
